// File: rtl/mdu.sv
// mdu: multi-cycle radix-2 multiply/divide unit holding the HI/LO pair (ports: clk, rst active-low sync, start/op/src_a/src_b launch, hi_wen/lo_wen/wdata mthi/mtlo, busy/done status, hi/lo results)
module mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             hi_wen,
  input  logic             lo_wen,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_r;
  logic [WIDTH-1:0]   a_mag, b_mag, a_raw, a_in, b_in, q_fix, r_fix;
  logic               neg_q, neg_r, sa, sb;
  logic [2*WIDTH-1:0] acc, acc_nxt, prod;
  logic [WIDTH:0]     m_sum;
  logic [2*WIDTH:0]   d_sh;
  logic [WIDTH+1:0]   d_diff;
  always_comb begin
    sa      = !op[0] & src_a[WIDTH-1];
    sb      = !op[0] & src_b[WIDTH-1];
    a_in    = sa ? -src_a : src_a;
    b_in    = sb ? -src_b : src_b;
    // multiply: add multiplicand into the upper half when the low bit is set, then shift right
    m_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : '0);
    // divide: shift {rem,quot} left and keep the trial subtract when it stays non-negative
    d_sh    = {acc, 1'b0};
    d_diff  = {1'b0, d_sh[2*WIDTH:WIDTH]} - {2'b0, b_mag};
    acc_nxt = op_r[1] ? (d_diff[WIDTH+1] ? d_sh[2*WIDTH-1:0]
                                         : {d_diff[WIDTH-1:0], d_sh[WIDTH-1:1], 1'b1})
                      : {m_sum, acc[WIDTH-1:1]};
    prod    = neg_q ? -acc : acc;
    q_fix   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_r  <= op;
            a_raw <= src_a;
            a_mag <= a_in;
            b_mag <= b_in;
            neg_q <= sa ^ sb;
            neg_r <= sa;
            acc   <= op[1] ? {{WIDTH{1'b0}}, a_in} : {{WIDTH{1'b0}}, b_in};
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            if (hi_wen) hi <= wdata;
            if (lo_wen) lo <= wdata;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            cnt   <= '0;
            state <= FIX;
          end
        end
        FIX: begin
          if (op_r[1]) begin
            // divide by zero returns all-ones quotient and the raw dividend
            hi <= (b_mag == '0) ? a_raw : r_fix;
            lo <= (b_mag == '0) ? '1 : q_fix;
          end else begin
            {hi, lo} <= prod;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu.sv
// tb_mdu: table-driven and sequence checks for the mdu multiply/divide unit
module tb_mdu;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] src_a = '0, src_b = '0, wdata = '0;
  logic        hi_wen = 1'b0, lo_wen = 1'b0;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          n_vec = 0;
  int          n_err = 0;

  mdu dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .hi_wen(hi_wen), .lo_wen(lo_wen), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
  } vec_t;

  vec_t tbl[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done is seen (or the bound expires).
  // disturb: write strobe alongside start, plus a second start and writes mid-CALC.
  task automatic do_op(input string name, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input bit disturb);
    int n;
    logic [31:0] lo_before;
    lo_before = lo;
    start = 1'b1; op = o; src_a = a; src_b = b;
    if (disturb) begin lo_wen = 1'b1; wdata = 32'hFFFF0000; end
    @(negedge clk);
    start = 1'b0; lo_wen = 1'b0;
    if (disturb) check({name, " write dropped on start"}, {32'd0, lo}, {32'd0, lo_before});
    n = 0;
    while (!done && n < 40) begin
      if (busy) n++;
      if (disturb && n == 5) begin
        start = 1'b1; op = 2'd1; src_a = 32'h11111111; src_b = 32'h22222222;
        hi_wen = 1'b1; lo_wen = 1'b1; wdata = 32'hCAFEF00D;
      end else begin
        start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; hi_wen = 1'b0; lo_wen = 1'b0;
    check({name, " busy cycles"}, 64'(n), 64'd33);
    check({name, " done"}, {63'd0, done}, 64'd1);
    check({name, " hi"}, {32'd0, hi}, {32'd0, eh});
    check({name, " lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  initial begin
    tbl = '{
      '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001},
      '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1},
      '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD},
      '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000},
      '{2'd3, 32'h00000064, 32'h00000000, 32'h00000064, 32'hFFFFFFFF},
      '{2'd2, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF},
      '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD},
      '{2'd2, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000002},
      '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000},
      '{2'd1, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000},
      '{2'd3, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF}
    };
    repeat (3) @(negedge clk);
    check("reset busy", {63'd0, busy}, 64'd0);
    check("reset done", {63'd0, done}, 64'd0);
    check("reset hi/lo", {hi, lo}, 64'd0);
    rst = 1'b1;
    @(negedge clk);

    hi_wen = 1'b1; wdata = 32'h12345678;
    @(negedge clk);
    hi_wen = 1'b0;
    check("mthi", {hi, lo}, {32'h12345678, 32'h0});
    hi_wen = 1'b1; lo_wen = 1'b1; wdata = 32'hAAAA5555;
    @(negedge clk);
    hi_wen = 1'b0; lo_wen = 1'b0;
    check("mthi+mtlo", {hi, lo}, {32'hAAAA5555, 32'hAAAA5555});

    do_op("divu 10/3 disturbed", 2'd3, 32'd10, 32'd3, 32'd1, 32'd3, 1'b1);
    @(negedge clk);
    check("done single pulse", {63'd0, done}, 64'd0);

    // every table entry starts on the edge right after the previous done
    for (int i = 0; i < 11; i++)
      do_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_hi, tbl[i].exp_lo, 1'b0);
    @(negedge clk);
    check("done low after table", {63'd0, done}, 64'd0);
    check("hi/lo hold in idle", {hi, lo}, {32'h0000000F, 32'h0FFFFFFF});

    start = 1'b1; op = 2'd0; src_a = 32'hFFFFFFFD; src_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("busy mid-op", {63'd0, busy}, 64'd1);
    rst = 1'b0;
    @(negedge clk);
    check("mid-op reset busy", {63'd0, busy}, 64'd0);
    check("mid-op reset hi/lo", {hi, lo}, 64'd0);
    check("mid-op reset done", {63'd0, done}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        if (done || busy) seen = 1'b1;
      end
      check("no activity after reset", {63'd0, seen}, 64'd0);
    end
    do_op("multu 6x7", 2'd1, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
